// File: rtl/flat_lane_accumulator_pkg.sv
// Shared constants, flat-bus bit positions, lane opcodes and a popcount helper
// for the flat lane accumulator.
// Latency: n/a (declarations only). Backpressure: n/a.
package flat_lane_accumulator_pkg;

   localparam int LANES = 8;
   localparam int DW    = 32;
   localparam int AW    = 40;
   localparam int CW    = $clog2(DW + 1);   // popcount width, holds 0..DW

   localparam int IN_W  = LANES * DW + 7;
   localparam int OUT_W = LANES * AW + LANES + 2;

   // Control field positions on in_flat (above the packed operands)
   localparam int OP_LSB    = LANES * DW;
   localparam int EN_BIT    = OP_LSB + 3;
   localparam int CLR_BIT   = OP_LSB + 4;
   localparam int SAT_BIT   = OP_LSB + 5;
   localparam int BCAST_BIT = OP_LSB + 6;

   // Status field positions on out_flat (above the packed accumulators)
   localparam int OVF_LSB    = LANES * AW;
   localparam int VALID_BIT  = OVF_LSB + LANES;
   localparam int PARITY_BIT = VALID_BIT + 1;

   typedef enum logic [2:0] {
      OP_ADD  = 3'd0,
      OP_SUB  = 3'd1,
      OP_XOR  = 3'd2,
      OP_LOAD = 3'd3,
      OP_SHL  = 3'd4,
      OP_MAX  = 3'd5,
      OP_HOLD = 3'd6,
      OP_CNT  = 3'd7
   } op_e;

   function automatic logic [CW-1:0] popcount(input logic [DW-1:0] v);
      logic [CW-1:0] n;
      n = '0;
      for (int i = 0; i < DW; i++) begin
         n = n + CW'(v[i]);
      end
      return n;
   endfunction

endpackage

// File: rtl/flat_lane_accumulator_lane_acc.sv
// Single accumulator lane: ALU for the eight ops plus acc and sticky ovf registers.
// Latency: 1 cycle from sampled inputs to acc/ovf. Backpressure: none, updates every enabled cycle.
// Ports: clk, rst_n (async low); clr/en/sat/op control; operand (DW); acc (AW), ovf outputs.
module lane_acc
   import flat_lane_accumulator_pkg::*;
(
   input  logic          clk,
   input  logic          rst_n,
   input  logic          clr,
   input  logic          en,
   input  logic          sat,
   input  logic [2:0]    op,
   input  logic [DW-1:0] operand,
   output logic [AW-1:0] acc,
   output logic          ovf
);

   localparam logic [AW-1:0] ACC_MAX = '1;

   logic [AW-1:0] x;
   logic [AW:0]   sum;
   logic [AW:0]   diff;
   logic [AW:0]   cnt_sum;
   logic [AW-1:0] nxt;
   logic          nxt_ovf;

   // The extra top bit of each AW+1 result is the carry (add) or borrow (sub).
   always_comb begin
      x       = {{(AW-DW){1'b0}}, operand};
      sum     = {1'b0, acc} + {1'b0, x};
      diff    = {1'b0, acc} - {1'b0, x};
      cnt_sum = {1'b0, acc} + (AW+1)'(popcount(operand));
      nxt     = acc;
      nxt_ovf = 1'b0;
      case (op_e'(op))
         OP_ADD: begin
            nxt_ovf = sum[AW];
            nxt     = (sum[AW] && sat) ? ACC_MAX : sum[AW-1:0];
         end
         OP_SUB: begin
            nxt_ovf = diff[AW];
            nxt     = (diff[AW] && sat) ? '0 : diff[AW-1:0];
         end
         OP_XOR:  nxt = acc ^ x;
         OP_LOAD: nxt = x;
         OP_SHL:  nxt = {acc[AW-2:0], x[0]};
         OP_MAX:  nxt = (x > acc) ? x : acc;
         OP_HOLD: nxt = acc;
         OP_CNT: begin
            nxt_ovf = cnt_sum[AW];
            nxt     = (cnt_sum[AW] && sat) ? ACC_MAX : cnt_sum[AW-1:0];
         end
         default: nxt = acc;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc <= '0;
         ovf <= 1'b0;
      end else if (clr) begin
         acc <= '0;
         ovf <= 1'b0;
      end else if (en) begin
         acc <= nxt;
         ovf <= ovf | nxt_ovf;   // sticky until clr or reset
      end
   end

endmodule

// File: rtl/flat_lane_accumulator.sv
// Eight-lane 40-bit accumulator array behind one flat input bus and one flat output bus.
// Latency: 1 cycle, no combinational in-to-out path. Backpressure: none, one update per clock.
// Ports: clk, rst_n (async low); in_flat = {bcast,sat,clr,en,op[2:0],a[7..0]};
//        out_flat = {parity,valid,ovf[7:0],acc[7..0]}.
module flat_lane_accumulator
   import flat_lane_accumulator_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic [IN_W-1:0]  in_flat,
   output logic [OUT_W-1:0] out_flat
);

   logic [2:0]          op;
   logic                en;
   logic                clr;
   logic                sat;
   logic                bcast;
   logic [LANES*AW-1:0] acc_flat;
   logic [LANES-1:0]    ovf_vec;
   logic                valid;
   logic                parity;

   assign op    = in_flat[OP_LSB +: 3];
   assign en    = in_flat[EN_BIT];
   assign clr   = in_flat[CLR_BIT];
   assign sat   = in_flat[SAT_BIT];
   assign bcast = in_flat[BCAST_BIT];

   for (genvar i = 0; i < LANES; i++) begin : g_lane
      logic [DW-1:0] operand;
      // Broadcast steers lane 0's operand to every lane.
      assign operand = bcast ? in_flat[DW-1:0] : in_flat[DW*i +: DW];

      lane_acc u_lane (
         .clk     (clk),
         .rst_n   (rst_n),
         .clr     (clr),
         .en      (en),
         .sat     (sat),
         .op      (op),
         .operand (operand),
         .acc     (acc_flat[AW*i +: AW]),
         .ovf     (ovf_vec[i])
      );
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid <= 1'b0;
      end else begin
         valid <= en & ~clr;
      end
   end

   // Parity is taken from the registers only, so it adds no input path.
   assign parity   = ^acc_flat;
   assign out_flat = {parity, valid, ovf_vec, acc_flat};

endmodule

// File: tb/tb_flat_lane_accumulator.sv
module tb_flat_lane_accumulator;
   import flat_lane_accumulator_pkg::*;

   localparam longint unsigned LIM   = 64'h100_0000_0000;
   localparam longint unsigned MAX40 = 64'h0FF_FFFF_FFFF;

   logic             clk = 1'b0;
   logic             rst_n;
   logic [IN_W-1:0]  in_flat;
   logic [OUT_W-1:0] out_flat;

   int passed = 0;
   int total  = 0;

   // reference model state
   logic [AW-1:0] m_acc [LANES];
   logic          m_ovf [LANES];
   logic          m_valid;

   typedef struct {
      logic [2:0]    op;
      logic [31:0]   a;
      logic          en;
      logic          clr;
      logic          sat;
      logic [AW-1:0] exp_acc;
      logic          exp_ovf;
      logic          exp_valid;
   } vec_t;

   vec_t tbl [21];

   flat_lane_accumulator dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_flat  (in_flat),
      .out_flat (out_flat)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [OUT_W-1:0] act, input logic [OUT_W-1:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   task automatic model_reset();
      for (int i = 0; i < LANES; i++) begin
         m_acc[i] = '0;
         m_ovf[i] = 1'b0;
      end
      m_valid = 1'b0;
   endtask

   task automatic model_clock(input logic [IN_W-1:0] v);
      logic [31:0]     opnd;
      longint unsigned a_, xv, r;
      logic            o;
      logic            s;
      if (v[CLR_BIT]) begin
         model_reset();
      end else if (v[EN_BIT]) begin
         s = v[SAT_BIT];
         for (int i = 0; i < LANES; i++) begin
            opnd = v[BCAST_BIT] ? v[31:0] : v[32*i +: 32];
            a_   = longint'(m_acc[i]);
            xv   = longint'(opnd);
            o    = 1'b0;
            case (v[OP_LSB +: 3])
               3'd0, 3'd7: begin
                  r = (v[OP_LSB +: 3] == 3'd0) ? a_ + xv : a_ + longint'($countones(opnd));
                  if (r >= LIM) begin
                     o = 1'b1;
                     r = s ? MAX40 : r - LIM;
                  end
               end
               3'd1: begin
                  if (xv > a_) begin
                     o = 1'b1;
                     r = s ? 64'd0 : a_ + LIM - xv;
                  end else r = a_ - xv;
               end
               3'd2: r = a_ ^ xv;
               3'd3: r = xv;
               3'd4: r = ((a_ << 1) | (xv & 64'd1)) & MAX40;
               3'd5: r = (xv > a_) ? xv : a_;
               default: r = a_;
            endcase
            m_acc[i] = r[AW-1:0];
            m_ovf[i] = m_ovf[i] | o;
         end
         m_valid = 1'b1;
      end else begin
         m_valid = 1'b0;
      end
   endtask

   function automatic logic [OUT_W-1:0] model_out();
      logic [OUT_W-1:0] r;
      logic             p;
      r = '0;
      p = 1'b0;
      for (int i = 0; i < LANES; i++) begin
         r[AW*i +: AW] = m_acc[i];
         r[OVF_LSB + i] = m_ovf[i];
         p = p ^ (^m_acc[i]);
      end
      r[VALID_BIT]  = m_valid;
      r[PARITY_BIT] = p;
      return r;
   endfunction

   function automatic logic [IN_W-1:0] mk(input logic [2:0] op, input logic en, input logic clr,
                                          input logic sat, input logic bcast, input logic [31:0] a0);
      logic [IN_W-1:0] v;
      v = '0;
      v[31:0]        = a0;
      v[OP_LSB +: 3] = op;
      v[EN_BIT]      = en;
      v[CLR_BIT]     = clr;
      v[SAT_BIT]     = sat;
      v[BCAST_BIT]   = bcast;
      return v;
   endfunction

   // Advance one clock; the model follows the DUT's sampling of in_flat.
   task automatic tick();
      @(posedge clk);
      if (rst_n) model_clock(in_flat);
      #1;
   endtask

   function automatic logic [31:0] lcg(input logic [31:0] s);
      return s * 32'd1664525 + 32'd1013904223;
   endfunction

   initial begin
      logic [OUT_W-1:0] exp;
      logic [AW-1:0]    e_acc;
      logic             p;
      logic [31:0]      seed;

      //                op       a              en    clr   sat   exp_acc              ovf   valid
      tbl[0]  = '{OP_LOAD, 32'h0000_1234, 1'b0, 1'b1, 1'b0, 40'h0,              1'b0, 1'b0};
      tbl[1]  = '{OP_CNT,  32'hF0F0_F0F0, 1'b1, 1'b0, 1'b0, 40'd16,             1'b0, 1'b1};
      tbl[2]  = '{OP_CNT,  32'hF0F0_F0F0, 1'b1, 1'b0, 1'b0, 40'd32,             1'b0, 1'b1};
      tbl[3]  = '{OP_CNT,  32'hF0F0_F0F0, 1'b1, 1'b0, 1'b0, 40'd48,             1'b0, 1'b1};
      tbl[4]  = '{OP_MAX,  32'h0000_0010, 1'b1, 1'b0, 1'b0, 40'd48,             1'b0, 1'b1};
      tbl[5]  = '{OP_SHL,  32'hF0F0_F0F0, 1'b1, 1'b0, 1'b0, 40'd96,             1'b0, 1'b1};
      tbl[6]  = '{OP_LOAD, 32'h0000_0005, 1'b0, 1'b0, 1'b0, 40'd96,             1'b0, 1'b0};
      tbl[7]  = '{OP_HOLD, 32'h0000_0005, 1'b1, 1'b0, 1'b0, 40'd96,             1'b0, 1'b1};
      tbl[8]  = '{OP_XOR,  32'h0000_00FF, 1'b1, 1'b0, 1'b0, 40'h9F,             1'b0, 1'b1};
      tbl[9]  = '{OP_MAX,  32'h0000_1000, 1'b1, 1'b0, 1'b0, 40'h1000,           1'b0, 1'b1};
      tbl[10] = '{OP_LOAD, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0, 40'hFF_FFFF_FFFF & 40'h00_FFFF_FFFF, 1'b0, 1'b1};
      tbl[11] = '{OP_SUB,  32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0, 40'h0,              1'b0, 1'b1};
      tbl[12] = '{OP_SUB,  32'h0000_0001, 1'b1, 1'b0, 1'b0, 40'hFF_FFFF_FFFF,   1'b1, 1'b1};
      tbl[13] = '{OP_ADD,  32'h0000_0001, 1'b1, 1'b0, 1'b0, 40'h0,              1'b1, 1'b1};
      tbl[14] = '{OP_SUB,  32'h0000_0005, 1'b1, 1'b0, 1'b1, 40'h0,              1'b1, 1'b1};
      tbl[15] = '{OP_ADD,  32'h0000_0007, 1'b1, 1'b0, 1'b0, 40'd7,              1'b1, 1'b1};
      tbl[16] = '{OP_SUB,  32'h0000_0008, 1'b1, 1'b0, 1'b0, 40'hFF_FFFF_FFFF,   1'b1, 1'b1};
      tbl[17] = '{OP_ADD,  32'h0000_0010, 1'b1, 1'b0, 1'b1, 40'hFF_FFFF_FFFF,   1'b1, 1'b1};
      tbl[18] = '{OP_CNT,  32'h0000_00FF, 1'b1, 1'b0, 1'b0, 40'd7,              1'b1, 1'b1};
      tbl[19] = '{OP_SUB,  32'h0000_0003, 1'b1, 1'b0, 1'b1, 40'd4,              1'b1, 1'b1};
      tbl[20] = '{OP_ADD,  32'h0000_0009, 1'b1, 1'b1, 1'b0, 40'h0,              1'b0, 1'b0};

      // ---- reset and idle after release ----
      rst_n   = 1'b0;
      in_flat = '0;
      model_reset();
      #2;
      check("reset_async", out_flat, '0);
      tick();
      tick();
      check("reset_held", out_flat, '0);
      rst_n = 1'b1;
      for (int c = 0; c < 3; c++) begin
         tick();
         check("idle_en0", out_flat, '0);
      end

      // ---- table-driven broadcast vectors: all lanes carry the same value ----
      for (int t = 0; t < 21; t++) begin
         in_flat = mk(tbl[t].op, tbl[t].en, tbl[t].clr, tbl[t].sat, 1'b1, tbl[t].a);
         tick();
         exp = '0;
         for (int i = 0; i < LANES; i++) begin
            exp[AW*i +: AW] = tbl[t].exp_acc;
            exp[OVF_LSB + i] = tbl[t].exp_ovf;
         end
         exp[VALID_BIT] = tbl[t].exp_valid;
         exp[PARITY_BIT] = 1'b0;   // eight identical lanes cancel
         check($sformatf("vec%0d", t), out_flat, exp);
      end

      // ---- per-lane LOAD i+1, then ADD 0xFFFFFFFF ----
      in_flat = mk(OP_LOAD, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0);
      for (int i = 0; i < LANES; i++) in_flat[32*i +: 32] = 32'(i + 1);
      tick();
      in_flat = mk(OP_ADD, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0);
      for (int i = 0; i < LANES; i++) in_flat[32*i +: 32] = 32'hFFFF_FFFF;
      tick();
      exp = '0;
      p   = 1'b0;
      for (int i = 0; i < LANES; i++) begin
         e_acc = 40'h01_0000_0000 + 40'(i);
         exp[AW*i +: AW] = e_acc;
         p = p ^ (^e_acc);
      end
      exp[VALID_BIT]  = 1'b1;
      exp[PARITY_BIT] = p;
      check("lane_add_carry", out_flat, exp);

      // ---- lane 0 borrow, wrap then saturate, then clr beats en ----
      in_flat = mk(OP_LOAD, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0);
      tick();
      in_flat = mk(OP_SUB, 1'b1, 1'b0, 1'b0, 1'b0, 32'd1);
      tick();
      check("sub_wrap_acc0", OUT_W'(out_flat[AW-1:0]), OUT_W'(40'hFF_FFFF_FFFF));
      check("sub_wrap_ovf",  OUT_W'(out_flat[OVF_LSB +: LANES]), OUT_W'(8'h01));
      in_flat = mk(OP_LOAD, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0);
      tick();
      in_flat = mk(OP_SUB, 1'b1, 1'b0, 1'b1, 1'b0, 32'd1);
      tick();
      exp = '0;
      exp[OVF_LSB]   = 1'b1;
      exp[VALID_BIT] = 1'b1;
      check("sub_sat", out_flat, exp);
      in_flat = mk(OP_ADD, 1'b1, 1'b1, 1'b0, 1'b0, 32'd5);
      tick();
      check("clr_over_en", out_flat, '0);

      // ---- asynchronous reset between clock edges ----
      in_flat = mk(OP_LOAD, 1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_ABCD);
      tick();
      check("pre_async_model", out_flat, model_out());
      #2;
      rst_n = 1'b0;
      #1;
      model_reset();
      check("async_mid_cycle", out_flat, '0);
      in_flat = '0;
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      check("after_async", out_flat, '0);

      // ---- LCG random traffic against the model ----
      seed = 32'd4161807235;
      for (int c = 0; c < 1000; c++) begin
         rst_n = (c >= 2);
         if (!rst_n) model_reset();
         for (int w = 0; w < (IN_W + 31) / 32; w++) begin
            seed = lcg(seed);
            for (int b = 0; b < 32; b++) begin
               if (32*w + b < IN_W) in_flat[32*w + b] = seed[b];
            end
         end
         tick();
         check($sformatf("rand%0d", c), out_flat, model_out());
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/flat_lane_accumulator.md
Name: flat_lane_accumulator

Overview:
- Eight-lane, 40-bit registered accumulator array behind a single flat input bus and a single flat output bus.
- Each clock, one shared 3-bit opcode is applied to every lane: its 32-bit operand updates its accumulator.
- Status bits report per-lane sticky overflow, a valid strobe and accumulator parity.
- Used as a standalone datapath block driven entirely through the flat buses.

Parameters:
- LANES, 8, number of lanes.
- DW, 32, lane operand width.
- AW, 40, accumulator width.
- Flat widths are fixed by these: in_flat = LANES*DW+7 = 263; out_flat = LANES*AW+LANES+2 = 330.
- Non-default values only rescale these formulas.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- in_flat  in  263  operands and control.
- out_flat  out  330  accumulators and status.

Behaviour:
- Input map:
  - a[i] = in_flat[32*i+31 : 32*i], i = 0..7.
  - op = in_flat[258:256].
  - en = in_flat[259].
  - clr = in_flat[260].
  - sat = in_flat[261].
  - bcast = in_flat[262]. When 1, every lane uses a[0] as its operand.
- Output map:
  - acc[i] = out_flat[40*i+39 : 40*i].
  - ovf[i] = out_flat[320+i].
  - valid = out_flat[328].
  - parity = out_flat[329], the XOR-reduce of all 320 accumulator bits, combinational from registers.
- All state is registered; inputs sampled on rising clk; results visible 1 cycle later. No combinational in-to-out path.
- Reset (rst_n=0, asynchronous): all acc, ovf and valid go to 0, hence parity=0. Reset mid-operation discards the in-progress update.
- Priority: clr > en.
  - clr=1: all acc and ovf go to 0, valid goes to 0, op ignored.
  - en=0 (clr=0): acc and ovf hold, valid goes to 0.
  - en=1 (clr=0): each lane applies op, valid goes to 1.
- Ops. x = zero-extended operand (40 bits).
  - 0 ADD: acc + x.
  - 1 SUB: acc - x.
  - 2 XOR: acc ^ x.
  - 3 LOAD: x.
  - 4 SHL: {acc[38:0], x[0]}.
  - 5 MAX: unsigned max(acc, x).
  - 6 HOLD: acc.
  - 7 CNT: acc + popcount(operand), a value of 0..32.
- Overflow:
  - ADD/CNT carry out of bit 39, or SUB borrow, sets ovf[i]. ovf is sticky until clr or reset.
  - Other ops never set ovf.
- Overflow result, sat=0: result wraps modulo 2^40.
- Overflow result, sat=1: ADD/CNT clamp to 0xFF_FFFF_FFFF; SUB clamps to 0. ovf is still set.
- Lanes are independent; no cross-lane carries.

Decomposition:
- Package flat_lane_accumulator_pkg holds:
  - LANES/DW/AW constants.
  - Control bit-position localparams.
  - Op enum: OP_ADD, OP_SUB, OP_XOR, OP_LOAD, OP_SHL, OP_MAX, OP_HOLD, OP_CNT.
- One sub-module, lane_acc: a single-lane ALU plus acc/ovf registers, instantiated LANES times via generate.
- The top level does bus slicing, broadcast muxing, valid register and parity reduction.

Test Plan:
- Reset, then assert rst_n with en=0 -> out_flat == 0 for all cycles; valid=0.
- LOAD all lanes a[i]=i+1, then ADD with a[i]=0xFFFFFFFF -> acc[i] = 0x1_0000_0000 + i; ovf=0; valid=1; parity matches a model.
- LOAD lane0=0, SUB a=1, sat=0 -> acc0=0xFF_FFFF_FFFF, ovf[0]=1. Repeat with sat=1 -> acc0=0, ovf[0]=1. Then clr=1 with en=1 -> all acc and ovf 0.
- bcast=1, a[0]=0xF0F0F0F0, op=CNT, 3 cycles -> every acc = 48. MAX with 0x10 -> 48 unchanged. SHL with a[0] bit0=0 -> 96.
- Async reset asserted mid-cycle between edges -> out_flat goes to 0 immediately, without waiting for a clk edge.
- 1000 cycles of LCG-random in_flat (seed 4161807235), rst_n released after 2 cycles -> every out_flat matches the reference model cycle-for-cycle.
